// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Memory-stage load/store controller: drives a valid/ready request channel,
// waits for a one-cycle response pulse, and formats load data for writeback.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_write_m1,
   input  logic [1:0]            result_src_m1,
   input  logic [ADDR_WIDTH-1:0] alu_result_m1,
   input  logic [DATA_WIDTH-1:0] write_data_m1,
   input  logic [2:0]            funct3_m1,
   output logic [DATA_WIDTH-1:0] read_data_m1,
   output logic                  stall_m,
   output logic                  misalign_m,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [3:0]            bus_wstrb,
   input  logic                  bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_read_data;
   logic                  r_req_valid;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_is_load;
   logic [2:0]            r_funct3;
   logic [1:0]            r_offset;

   logic                  w_is_load;
   logic                  w_access;
   logic                  w_misaligned;
   logic [1:0]            w_offset;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                            input logic [1:0] off,
                                            input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b100:  fmt_load = {24'b0, b};
         3'b101:  fmt_load = {16'b0, h};
         default: fmt_load = word;
      endcase
   endfunction

   function automatic logic [31:0] fmt_wdata(input logic [1:0] size,
                                             input logic [31:0] wd);
      case (size)
         2'b00:   fmt_wdata = {4{wd[7:0]}};
         2'b01:   fmt_wdata = {2{wd[15:0]}};
         default: fmt_wdata = wd;
      endcase
   endfunction

   function automatic logic [3:0] fmt_wstrb(input logic [1:0] size,
                                            input logic [1:0] off);
      case (size)
         2'b00:   fmt_wstrb = 4'b0001 << off;
         2'b01:   fmt_wstrb = off[1] ? 4'b1100 : 4'b0011;
         default: fmt_wstrb = 4'b1111;
      endcase
   endfunction

   // A request with both store and load set is a store.
   assign w_is_load = ~mem_write_m1 & (result_src_m1 == 2'b01);
   assign w_access  = mem_write_m1 | (result_src_m1 == 2'b01);
   assign w_offset  = alu_result_m1[1:0];

   always_comb begin
      w_misaligned = 1'b0;
      case (funct3_m1[1:0])
         2'b10:   w_misaligned = (w_offset != 2'b00);
         2'b01:   w_misaligned = w_offset[0];
         default: w_misaligned = 1'b0;
      endcase
   end

   assign misalign_m = w_access & w_misaligned;
   assign stall_m    = w_access & ~w_misaligned & (r_state != DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_read_data <= '0;
         r_req_valid <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= 4'b0000;
         r_is_load   <= 1'b0;
         r_funct3    <= 3'b000;
         r_offset    <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_misaligned) begin
                     r_read_data <= '0;
                  end else begin
                     r_addr      <= {alu_result_m1[ADDR_WIDTH-1:2], 2'b00};
                     r_we        <= mem_write_m1;
                     r_wdata     <= fmt_wdata(funct3_m1[1:0], write_data_m1);
                     r_wstrb     <= mem_write_m1 ? fmt_wstrb(funct3_m1[1:0], w_offset) : 4'b0000;
                     r_is_load   <= w_is_load;
                     r_funct3    <= funct3_m1;
                     r_offset    <= w_offset;
                     r_req_valid <= 1'b1;
                     r_state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (bus_rsp_valid) begin
                  if (r_is_load)
                     r_read_data <= fmt_load(r_funct3, r_offset, bus_rdata);
                  r_state <= DONE;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign read_data_m1  = r_read_data;
   assign bus_req_valid = r_req_valid;
   assign bus_we        = r_we;
   assign bus_addr      = r_addr;
   assign bus_wdata     = r_wdata;
   assign bus_wstrb     = r_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Directed bench for mem_access_unit: loads, stores, bus wait states,
// misaligned accesses and reset in the middle of an access.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_write_m1;
   logic [1:0]  result_src_m1;
   logic [31:0] alu_result_m1;
   logic [31:0] write_data_m1;
   logic [2:0]  funct3_m1;
   logic [31:0] read_data_m1;
   logic        stall_m;
   logic        misalign_m;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_write_m1  (mem_write_m1),
      .result_src_m1 (result_src_m1),
      .alu_result_m1 (alu_result_m1),
      .write_data_m1 (write_data_m1),
      .funct3_m1     (funct3_m1),
      .read_data_m1  (read_data_m1),
      .stall_m       (stall_m),
      .misalign_m    (misalign_m),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_wstrb     (bus_wstrb),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rdata     (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      mem_write_m1  = 1'b0;
      result_src_m1 = 2'b00;
      alu_result_m1 = 32'h0;
      write_data_m1 = 32'h0;
      funct3_m1     = 3'b000;
   endtask

   // Presents one access and plays the bus side; returns once stall_m drops (DONE).
   task automatic run_access(input logic we, input logic [1:0] rs, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rdata,
                             input int rdy_wait, input int rsp_wait,
                             output int stalls, output int hs,
                             output logic [31:0] s_addr, output logic [31:0] s_wdata,
                             output logic [3:0] s_wstrb, output logic s_we,
                             output logic stable, output logic timeout);
      int   req_seen;
      int   wait_seen;
      logic got_req;
      @(negedge clk);
      mem_write_m1  = we;
      result_src_m1 = rs;
      alu_result_m1 = addr;
      write_data_m1 = wd;
      funct3_m1     = f3;
      bus_rdata     = rdata;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      stalls = 0; hs = 0; req_seen = 0; wait_seen = 0;
      got_req = 1'b0; stable = 1'b1; timeout = 1'b1;
      s_addr = 32'h0; s_wdata = 32'h0; s_wstrb = 4'h0; s_we = 1'b0;
      for (int c = 0; c < 60; c++) begin
         #1;
         bus_rsp_valid = 1'b0;
         if (!stall_m) begin
            timeout = 1'b0;
            break;
         end
         stalls++;
         if (bus_req_valid) begin
            if (!got_req) begin
               s_addr = bus_addr; s_wdata = bus_wdata; s_wstrb = bus_wstrb; s_we = bus_we;
            end else if (bus_addr !== s_addr || bus_wdata !== s_wdata ||
                         bus_wstrb !== s_wstrb || bus_we !== s_we) begin
               stable = 1'b0;
            end
            got_req = 1'b1;
            bus_req_ready = (req_seen >= rdy_wait);
            req_seen++;
            if (bus_req_ready) hs++;
         end else begin
            bus_req_ready = 1'b0;
            if (got_req) begin
               if (wait_seen == rsp_wait) bus_rsp_valid = 1'b1;
               wait_seen++;
            end
         end
         @(negedge clk);
      end
      clear_inputs();
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (read_data_m1 !== 32'h0) begin bad++; $display("FAIL rst_read_data got=%h exp=%h", read_data_m1, 32'h0); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus_req_valid); end
      total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus_we); end
      total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus_addr); end
      total++; if (bus_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus_wdata); end
      total++; if (bus_wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got=%b exp=0000", bus_wstrb); end
      total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_m); end
      // Combinational outputs follow the inputs even while reset is held.
      result_src_m1 = 2'b01; funct3_m1 = 3'b010; alu_result_m1 = 32'h102;
      #1;
      total++; if (misalign_m !== 1'b1) begin bad++; $display("FAIL rst_misalign_comb got=%b exp=1", misalign_m); end
      alu_result_m1 = 32'h100;
      #1;
      total++; if (stall_m !== 1'b1) begin bad++; $display("FAIL rst_stall_comb got=%b exp=1", stall_m); end
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lw();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      run_access(1'b0, 2'b01, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to) begin bad++; $display("FAIL lw_timeout got=timeout exp=done"); end
      total++; if (a !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=%h", a, 32'h100); end
      total++; if (s !== 4'b0000) begin bad++; $display("FAIL lw_wstrb got=%b exp=0000", s); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b exp=0", we); end
      total++; if (st != 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=3", st); end
      total++; if (hs != 1) begin bad++; $display("FAIL lw_handshakes got=%0d exp=1", hs); end
      total++; if (read_data_m1 !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=%h", read_data_m1, 32'hDEADBEEF); end
   endtask

   task automatic test_subword_loads();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      run_access(1'b0, 2'b01, 32'h103, 32'h0, 3'b000, 32'h80123456, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || read_data_m1 !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=%h", read_data_m1, 32'hFFFFFF80); end
      total++; if (a !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=%h", a, 32'h100); end
      run_access(1'b0, 2'b01, 32'h103, 32'h0, 3'b100, 32'h80123456, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || read_data_m1 !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=%h", read_data_m1, 32'h00000080); end
      run_access(1'b0, 2'b01, 32'h102, 32'h0, 3'b001, 32'h80123456, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || read_data_m1 !== 32'hFFFF8012) begin bad++; $display("FAIL lh_data got=%h exp=%h", read_data_m1, 32'hFFFF8012); end
      run_access(1'b0, 2'b01, 32'h102, 32'h0, 3'b101, 32'h80123456, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || read_data_m1 !== 32'h00008012) begin bad++; $display("FAIL lhu_data got=%h exp=%h", read_data_m1, 32'h00008012); end
      run_access(1'b0, 2'b01, 32'h101, 32'h0, 3'b000, 32'h80123456, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || read_data_m1 !== 32'h00000034) begin bad++; $display("FAIL lb1_data got=%h exp=%h", read_data_m1, 32'h00000034); end
   endtask

   task automatic test_stores();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      run_access(1'b1, 2'b00, 32'h202, 32'h000000AB, 3'b000, 32'h0, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || w !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=%h", w, 32'hABABABAB); end
      total++; if (s !== 4'b0100) begin bad++; $display("FAIL sb_wstrb got=%b exp=0100", s); end
      total++; if (we !== 1'b1) begin bad++; $display("FAIL sb_we got=%b exp=1", we); end
      total++; if (a !== 32'h200) begin bad++; $display("FAIL sb_addr got=%h exp=%h", a, 32'h200); end
      total++; if (read_data_m1 !== 32'h00000034) begin bad++; $display("FAIL sb_keeps_rdata got=%h exp=%h", read_data_m1, 32'h00000034); end
      run_access(1'b1, 2'b00, 32'h202, 32'h00001234, 3'b001, 32'h0, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || w !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%h exp=%h", w, 32'h12341234); end
      total++; if (s !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", s); end
      // Store wins when both request bits are set.
      run_access(1'b1, 2'b01, 32'h300, 32'hCAFE0001, 3'b010, 32'h55555555, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || w !== 32'hCAFE0001 || s !== 4'b1111 || we !== 1'b1) begin bad++; $display("FAIL sw_both wdata=%h wstrb=%b we=%b exp=cafe0001/1111/1", w, s, we); end
      total++; if (read_data_m1 !== 32'h00000034) begin bad++; $display("FAIL sw_keeps_rdata got=%h exp=%h", read_data_m1, 32'h00000034); end
   endtask

   task automatic test_wait_states();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      run_access(1'b0, 2'b01, 32'h400, 32'h0, 3'b010, 32'h13579BDF, 3, 2, st, hs, a, w, s, we, stb, to);
      total++; if (to) begin bad++; $display("FAIL wait_timeout got=timeout exp=done"); end
      total++; if (st != 8) begin bad++; $display("FAIL wait_stall_cycles got=%0d exp=8", st); end
      total++; if (hs != 1) begin bad++; $display("FAIL wait_handshakes got=%0d exp=1", hs); end
      total++; if (stb !== 1'b1) begin bad++; $display("FAIL wait_bus_stable got=%b exp=1", stb); end
      total++; if (read_data_m1 !== 32'h13579BDF) begin bad++; $display("FAIL wait_data got=%h exp=%h", read_data_m1, 32'h13579BDF); end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      result_src_m1 = 2'b01; funct3_m1 = 3'b010; alu_result_m1 = 32'h102;
      #1;
      total++; if (misalign_m !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misalign_m); end
      total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b exp=0", stall_m); end
      @(negedge clk);
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req_valid got=%b exp=0", bus_req_valid); end
      total++; if (read_data_m1 !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", read_data_m1); end
      funct3_m1 = 3'b001; alu_result_m1 = 32'h101;
      #1;
      total++; if (misalign_m !== 1'b1 || stall_m !== 1'b0) begin bad++; $display("FAIL mis_half misalign=%b stall=%b exp=1/0", misalign_m, stall_m); end
      funct3_m1 = 3'b000; alu_result_m1 = 32'h103;
      #1;
      total++; if (misalign_m !== 1'b0) begin bad++; $display("FAIL byte_aligned got=%b exp=0", misalign_m); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      @(negedge clk);
      result_src_m1 = 2'b01; funct3_m1 = 3'b010; alu_result_m1 = 32'h100;
      bus_rdata = 32'hDEADBEEF; bus_req_ready = 1'b1;
      @(negedge clk);
      total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_req got=%b exp=1", bus_req_valid); end
      @(negedge clk);
      rst = 1'b1; bus_req_ready = 1'b0; clear_inputs();
      @(negedge clk);
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_valid got=%b exp=0", bus_req_valid); end
      rst = 1'b0; bus_rsp_valid = 1'b1;
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      total++; if (read_data_m1 !== 32'h0) begin bad++; $display("FAIL rmid_late_rsp got=%h exp=0", read_data_m1); end
      // A fresh access taking the minimum latency shows the FSM restarted from IDLE.
      run_access(1'b0, 2'b01, 32'h500, 32'h0, 3'b010, 32'h0BADF00D, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || st != 3) begin bad++; $display("FAIL rmid_restart_stall got=%0d exp=3", st); end
      total++; if (read_data_m1 !== 32'h0BADF00D) begin bad++; $display("FAIL rmid_restart_data got=%h exp=%h", read_data_m1, 32'h0BADF00D); end
   endtask

   task automatic test_back_to_back();
      int st, hs; logic [31:0] a, w; logic [3:0] s; logic we, stb, to;
      run_access(1'b1, 2'b00, 32'h601, 32'h000000C3, 3'b000, 32'h0, 0, 0, st, hs, a, w, s, we, stb, to);
      total++; if (to || st != 3 || s !== 4'b0010) begin bad++; $display("FAIL b2b_store stall=%0d wstrb=%b exp=3/0010", st, s); end
      run_access(1'b0, 2'b01, 32'h606, 32'h0, 3'b001, 32'h7FFF1234, 0, 1, st, hs, a, w, s, we, stb, to);
      total++; if (to || st != 4 || hs != 1) begin bad++; $display("FAIL b2b_load stall=%0d hs=%0d exp=4/1", st, hs); end
      total++; if (read_data_m1 !== 32'h00007FFF) begin bad++; $display("FAIL b2b_data got=%h exp=%h", read_data_m1, 32'h00007FFF); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_subword_loads();
      test_stores();
      test_wait_states();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
